control_unit_fsm: RTL and testbench

- Multi-cycle control unit for the 32-bit cs147sec05 processor, directly upstream of the datapath.
- Consumes the datapath's INSTRUCTION and ZERO outputs, and produces the 32-bit CTRL word that steers the datapath muxes, register file, SP/PC loads and memory strobes.
- Sequences every instruction through a fixed 5-state FSM.

---
 rtl/control_unit_fsm_pkg.sv | 116 +++++++++++
 rtl/control_unit_fsm_decode.sv | 117 +++++++++++
 rtl/control_unit_fsm.sv | 90 +++++++++
 tb/tb_control_unit_fsm.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/control_unit_fsm_pkg.sv
// Shared definitions for the cs147sec05 control unit: opcodes, ALU codes, CTRL bit map, states.
// ILLEGAL_TRAP_EN adds the HALT state used for unknown encodings.
package control_unit_fsm_pkg;

  localparam int CTRL_W = 32;
  localparam logic [CTRL_W-1:0] FETCH_VEC = 32'h8000_0010;

  // CTRL bit indices
  localparam int PC_LOAD   = 0;
  localparam int PC_SEL_1  = 1;
  localparam int PC_SEL_2  = 2;
  localparam int PC_SEL_3  = 3;
  localparam int MEM_R     = 4;
  localparam int MEM_W     = 5;
  localparam int R1_SEL_1  = 6;
  localparam int REG_R     = 7;
  localparam int REG_W     = 8;
  localparam int WA_SEL_1  = 9;
  localparam int WA_SEL_2  = 10;
  localparam int WA_SEL_3  = 11;
  localparam int WD_SEL_1  = 12;
  localparam int WD_SEL_2  = 13;
  localparam int WD_SEL_3  = 14;
  localparam int SP_LOAD   = 15;
  localparam int OP1_SEL_1 = 16;
  localparam int OP2_SEL_1 = 17;
  localparam int OP2_SEL_2 = 18;
  localparam int OP2_SEL_3 = 19;
  localparam int OP2_SEL_4 = 20;
  localparam int ALU_LO    = 21;
  localparam int ALU_HI    = 25;
  localparam int MA_SEL_1  = 26;
  localparam int R2_LD     = 27;
  localparam int MD_SEL_1  = 29;
  localparam int R1_LD     = 30;
  localparam int MA_SEL_2  = 31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h01;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a;
  localparam logic [5:0] F_MUL = 6'h2c;

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_MUL = 5'd3;
  localparam logic [4:0] ALU_SHR = 5'd4;
  localparam logic [4:0] ALU_SHL = 5'd5;
  localparam logic [4:0] ALU_AND = 5'd6;
  localparam logic [4:0] ALU_OR  = 5'd7;
  localparam logic [4:0] ALU_NOR = 5'd8;
  localparam logic [4:0] ALU_SLT = 5'd9;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
`ifdef ILLEGAL_TRAP_EN
    S_WB     = 3'd4,
    S_HALT   = 3'd5
`else
    S_WB     = 3'd4
`endif
  } state_t;

  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

  typedef struct packed {
    logic [CTRL_W-1:0] sel;
    logic              reg_w;
    logic              mem_r;
    logic              mem_w;
    logic              sp_load;
    br_t               br;
    logic              illegal;
  } dec_t;

  // ALU code for the register-register funct values; 0 for anything else
  function automatic logic [4:0] funct_alu(input logic [5:0] f);
    case (f)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_MUL:   funct_alu = ALU_MUL;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_NOR:   funct_alu = ALU_NOR;
      F_SLT:   funct_alu = ALU_SLT;
      F_SLL:   funct_alu = ALU_SHL;
      F_SRL:   funct_alu = ALU_SHR;
      default: funct_alu = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_fsm_decode.sv
// control_decode: maps opcode/funct of the latched IR to the held select fields and class flags.
// Strobes (reg_w, mem_r, mem_w, sp_load, branch) are only flags here; the FSM gates them by state.
module control_decode
  import control_unit_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec               = '0;
    dec.br            = BR_NONE;
    dec.sel[PC_SEL_1] = 1'b1;
    dec.sel[PC_SEL_3] = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_MUL, F_AND, F_OR, F_NOR, F_SLT: begin
            dec.sel[ALU_HI:ALU_LO] = funct_alu(funct);
            dec.sel[OP2_SEL_4]     = 1'b1;
            dec.sel[WA_SEL_3]      = 1'b1;
            dec.sel[WD_SEL_3]      = 1'b1;
            dec.reg_w              = 1'b1;
          end
          F_SLL, F_SRL: begin
            dec.sel[ALU_HI:ALU_LO] = funct_alu(funct);
            dec.sel[OP2_SEL_3]     = 1'b1;
            dec.sel[OP2_SEL_1]     = 1'b1;
            dec.sel[WA_SEL_3]      = 1'b1;
            dec.sel[WD_SEL_3]      = 1'b1;
            dec.reg_w              = 1'b1;
          end
          F_JR: begin
            dec.sel[PC_SEL_1] = 1'b0;
            dec.sel[PC_SEL_2] = 1'b0;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_MULI, OP_SLTI, OP_ANDI, OP_ORI: begin
        case (op)
          OP_ADDI: dec.sel[ALU_HI:ALU_LO] = ALU_ADD;
          OP_MULI: dec.sel[ALU_HI:ALU_LO] = ALU_MUL;
          OP_SLTI: dec.sel[ALU_HI:ALU_LO] = ALU_SLT;
          OP_ANDI: dec.sel[ALU_HI:ALU_LO] = ALU_AND;
          default: dec.sel[ALU_HI:ALU_LO] = ALU_OR;
        endcase
        // andi/ori take the zero-extended immediate
        dec.sel[OP2_SEL_2] = (op != OP_ANDI) && (op != OP_ORI);
        dec.sel[WA_SEL_1]  = 1'b1;
        dec.sel[WA_SEL_3]  = 1'b1;
        dec.sel[WD_SEL_3]  = 1'b1;
        dec.reg_w          = 1'b1;
      end
      OP_LUI: begin
        dec.sel[WD_SEL_2] = 1'b1;
        dec.sel[WD_SEL_3] = 1'b1;
        dec.sel[WA_SEL_1] = 1'b1;
        dec.sel[WA_SEL_3] = 1'b1;
        dec.reg_w         = 1'b1;
      end
      OP_LW: begin
        dec.sel[ALU_HI:ALU_LO] = ALU_ADD;
        dec.sel[OP2_SEL_2]     = 1'b1;
        dec.sel[WD_SEL_1]      = 1'b1;
        dec.sel[WD_SEL_3]      = 1'b1;
        dec.sel[WA_SEL_1]      = 1'b1;
        dec.sel[WA_SEL_3]      = 1'b1;
        dec.mem_r              = 1'b1;
        dec.reg_w              = 1'b1;
      end
      OP_SW: begin
        dec.sel[ALU_HI:ALU_LO] = ALU_ADD;
        dec.sel[OP2_SEL_2]     = 1'b1;
        dec.mem_w              = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.sel[ALU_HI:ALU_LO] = ALU_SUB;
        dec.sel[OP2_SEL_4]     = 1'b1;
        dec.br                 = (op == OP_BEQ) ? BR_EQ : BR_NE;
      end
      OP_JMP: dec.sel[PC_SEL_3] = 1'b0;
      OP_JAL: begin
        // return address PC+1 goes to r31
        dec.sel[PC_SEL_3] = 1'b0;
        dec.sel[WA_SEL_2] = 1'b1;
        dec.reg_w         = 1'b1;
      end
      OP_PUSH: begin
        dec.sel[R1_SEL_1]      = 1'b1;
        dec.sel[OP1_SEL_1]     = 1'b1;
        dec.sel[ALU_HI:ALU_LO] = ALU_SUB;
        dec.sel[OP2_SEL_3]     = 1'b1;
        dec.sel[MA_SEL_1]      = 1'b1;
        dec.sel[MD_SEL_1]      = 1'b1;
        dec.mem_w              = 1'b1;
        dec.sp_load            = 1'b1;
      end
      OP_POP: begin
        // pop reads from the incremented SP, so the address comes from the ALU
        dec.sel[OP1_SEL_1]     = 1'b1;
        dec.sel[ALU_HI:ALU_LO] = ALU_ADD;
        dec.sel[OP2_SEL_3]     = 1'b1;
        dec.sel[WD_SEL_1]      = 1'b1;
        dec.sel[WD_SEL_3]      = 1'b1;
        dec.sel[WA_SEL_1]      = 1'b1;
        dec.sel[WA_SEL_3]      = 1'b1;
        dec.mem_r              = 1'b1;
        dec.reg_w              = 1'b1;
        dec.sp_load            = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Five-state multi-cycle control unit: owns state, IR and state gating of the CTRL strobes.
// Build option ILLEGAL_TRAP_EN: unknown encodings park the FSM in HALT until reset.
module control_unit_fsm
  import control_unit_fsm_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INSTRUCTION,
  input  logic              ZERO,
  output logic [CTRL_W-1:0] CTRL,
  output logic [2:0]        STATE
);

  state_t      state, state_nxt;
  logic [31:0] ir;
  dec_t        dec;
  logic        unused_ir;

  control_decode u_dec (
    .op    (ir[31:26]),
    .funct (ir[5:0]),
    .dec   (dec)
  );

  assign unused_ir = ^ir[25:6];
  assign STATE     = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 ir <= '0;
    else if (state == S_FETCH) ir <= INSTRUCTION;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
`ifdef ILLEGAL_TRAP_EN
      S_DECODE: state_nxt = dec.illegal ? S_HALT : S_EXE;
      S_HALT:   state_nxt = S_HALT;
`else
      S_DECODE: state_nxt = S_EXE;
`endif
      S_EXE:    state_nxt = S_MEM;
      S_MEM:    state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    CTRL = FETCH_VEC;
    case (state)
      S_FETCH: CTRL = FETCH_VEC;
      S_DECODE: begin
        CTRL        = dec.sel;
        CTRL[REG_R] = 1'b1;
        CTRL[R1_LD] = 1'b1;
        CTRL[R2_LD] = 1'b1;
      end
      S_EXE: CTRL = dec.sel;
      S_MEM: begin
        CTRL        = dec.sel;
        CTRL[MEM_R] = dec.mem_r;
        CTRL[MEM_W] = dec.mem_w;
      end
      S_WB: begin
        CTRL          = dec.sel;
        CTRL[PC_LOAD] = 1'b1;
        CTRL[REG_W]   = dec.reg_w;
        CTRL[SP_LOAD] = dec.sp_load;
        // ZERO only matters here; branch target chosen from the ALU compare
        case (dec.br)
          BR_EQ:   CTRL[PC_SEL_2] = ZERO;
          BR_NE:   CTRL[PC_SEL_2] = ~ZERO;
          default: CTRL[PC_SEL_2] = dec.sel[PC_SEL_2];
        endcase
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: CTRL = '0;
`endif
      default: CTRL = FETCH_VEC;
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: hand-derived per-state CTRL/STATE expectations via a scoreboard queue.
module tb_control_unit_fsm;

  logic        CLK, RST, ZERO;
  logic [31:0] INSTRUCTION;
  logic [31:0] CTRL;
  logic [2:0]  STATE;

  localparam logic [31:0] FV    = 32'h8000_0010;
  localparam logic [31:0] I_ADD = 32'h0022_1820;
  localparam logic [31:0] I_BEQ = 32'h1022_0003;
  localparam logic [31:0] I_LW  = 32'h8C22_0004;
  localparam logic [31:0] I_JAL = 32'h0C00_0100;
  localparam logic [31:0] I_PSH = 32'h6C00_0000;
  localparam logic [31:0] I_ILL = 32'hFC00_0000;

  typedef struct {
    logic [31:0] ctrl;
    logic [2:0]  st;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  control_unit_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .CTRL        (CTRL),
    .STATE       (STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] oc, input logic [31:0] ec,
                     input logic [2:0] os, input logic [2:0] es);
    n_cmp++;
    assert (oc === ec) else begin
      n_mis++;
      $error("FAIL %s CTRL observed %h expected %h", tag, oc, ec);
    end
    n_cmp++;
    assert (os === es) else begin
      n_mis++;
      $error("FAIL %s STATE observed %0d expected %0d", tag, os, es);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] c, input logic [2:0] s);
    exp_t e;
    e.ctrl = c;
    e.st   = s;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic push5(input string tag, input logic [31:0] d, input logic [31:0] x,
                       input logic [31:0] m, input logic [31:0] w);
    push({tag, "/fetch"},  FV, 3'd0);
    push({tag, "/decode"}, d,  3'd1);
    push({tag, "/exe"},    x,  3'd2);
    push({tag, "/mem"},    m,  3'd3);
    push({tag, "/wb"},     w,  3'd4);
  endtask

  // Caller is mid-cycle before a FETCH cycle; samples n cycles at negedge+1.
  // ZERO is the opposite of zwb outside WB so any sampling there would show up.
  task automatic run(input logic [31:0] instr, input logic zwb, input int n);
    exp_t e;
    INSTRUCTION = instr;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      ZERO = (k == 4) ? zwb : ~zwb;
      #1;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_mis++;
        $error("FAIL scoreboard_empty observed size 0 expected >0");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.tag, CTRL, e.ctrl, STATE, e.st);
      end
    end
  endtask

  initial begin
    RST = 1'b0; INSTRUCTION = '0; ZERO = 1'b0;
    #3;
    chk("reset", CTRL, FV, STATE, 3'd0);
    @(posedge CLK); #2 RST = 1'b1;

    // reset in the middle of EXE aborts the add
    push("abort/fetch",  FV,           3'd0);
    push("abort/decode", 32'h4830_488A, 3'd1);
    push("abort/exe",    32'h0030_480A, 3'd2);
    run(I_ADD, 1'b0, 3);
    RST = 1'b0;
    #1 chk("abort_now", CTRL, FV, STATE, 3'd0);
    @(posedge CLK);
    #1 chk("abort_hold", CTRL, FV, STATE, 3'd0);
    #1 RST = 1'b1;

    push5("add",    32'h4830_488A, 32'h0030_480A, 32'h0030_480A, 32'h0030_490B);
    run(I_ADD, 1'b0, 5);
    push5("beq_z1", 32'h4850_008A, 32'h0050_000A, 32'h0050_000A, 32'h0050_000F);
    run(I_BEQ, 1'b1, 5);
    push5("beq_z0", 32'h4850_008A, 32'h0050_000A, 32'h0050_000A, 32'h0050_000B);
    run(I_BEQ, 1'b0, 5);
    push5("lw",     32'h4824_5A8A, 32'h0024_5A0A, 32'h0024_5A1A, 32'h0024_5B0B);
    run(I_LW, 1'b0, 5);
    push5("jal",    32'h4800_0482, 32'h0000_0402, 32'h0000_0402, 32'h0000_0503);
    run(I_JAL, 1'b0, 5);
    push5("push",   32'h6C49_00CA, 32'h2449_004A, 32'h2449_006A, 32'h2449_804B);
    run(I_PSH, 1'b0, 5);

`ifdef ILLEGAL_TRAP_EN
    push("ill/fetch",  FV,            3'd0);
    push("ill/decode", 32'h4800_008A, 3'd1);
    push("ill/halt0",  32'h0,         3'd5);
    push("ill/halt1",  32'h0,         3'd5);
    push("ill/halt2",  32'h0,         3'd5);
    run(I_ILL, 1'b0, 5);
    RST = 1'b0;
    #1 chk("halt_reset", CTRL, FV, STATE, 3'd0);
    @(posedge CLK); #2 RST = 1'b1;
`else
    push5("nop", 32'h4800_008A, 32'h0000_000A, 32'h0000_000A, 32'h0000_000B);
    run(I_ILL, 1'b0, 5);
`endif

    push5("add2", 32'h4830_488A, 32'h0030_480A, 32'h0030_480A, 32'h0030_490B);
    run(I_ADD, 1'b0, 5);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_mis++;
      $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
